seq_multiplier: RTL
===================

# seq_multiplier

Sequential shift-and-add multiplier that sits upstream of the 16-bit `register` block. It accepts two operands on a start pulse and iterates one partial product per clock. It then presents the low half of the product on `write_word` together with a one-cycle `enable` strobe, so its outputs connect directly to a destination register's `write_word`/`enable` inputs. An `overflow` flag reports a nonzero high half.

## Interface
- `WIDTH`, 16, operand and result width in bits
- `clock`  input  1  system clock; all state updates on rising edge
- `reset`  input  1  synchronous, active-low; sampled on rising edge of `clock`
- `start`  input  1  request a multiply; sampled only in IDLE
- `a`  input  WIDTH  multiplicand; captured on the accepting edge
- `b`  input  WIDTH  multiplier; captured on the accepting edge
- `busy`  output  1  high in RUN and DONE
- `write_word`  output  WIDTH  low WIDTH bits of a×b; held until the next accepted start
- `enable`  output  1  one-cycle strobe, high only in DONE; drives the downstream register's `enable`
- `overflow`  output  1  high if bits [2·WIDTH-1:WIDTH] of the product are nonzero; updated and held with `write_word`

## Operation
- Operands are unsigned. The internal accumulator is 2·WIDTH bits wide. The shifted multiplicand register is 2·WIDTH bits wide. The iteration counter is $clog2(WIDTH)+1 bits wide.
- States: IDLE, RUN, DONE.
- **IDLE**
  - If `start`=1, load the multiplicand register with zero-extended `a`.
  - Load the multiplier register with `b`, clear the accumulator, and clear the counter.
  - Go to RUN.
  - Otherwise stay in IDLE.
- **RUN**, each edge:
  - If multiplier[0]=1, add the multiplicand register to the accumulator (mod 2^(2·WIDTH)).
  - Shift the multiplicand left by 1 and the multiplier right by 1, and increment the counter.
  - After exactly WIDTH RUN edges, go to DONE and load `write_word` with acc[WIDTH-1:0] and `overflow` with |acc[2·WIDTH-1:WIDTH].
  - There is no early termination; iteration count is always WIDTH.
- **DONE**: `enable`=1. Go to IDLE unconditionally on the next edge.
- `start` is ignored in RUN and DONE. It is not queued.
- `a` and `b` may change freely after the accepting edge without affecting the result.

## Timing
- Reset (`reset`=0 at an edge): state to IDLE. `busy`=0, `enable`=0, `write_word`=0, `overflow`=0, accumulator and counter cleared.
- Reset asserted mid-RUN or in DONE aborts the operation. No `enable` pulse is produced.
- Reset has priority over `start` on the same edge.
- Let E0 be the edge where `start` is accepted:
  - `busy` rises after E0.
  - `write_word`, `overflow` and `enable` become valid after edge E0+WIDTH (E0+16 by default).
  - `enable` falls after E0+WIDTH+1, and so does `busy`.
- Total occupancy per operation is WIDTH+1 cycles.
- Back-to-back: the earliest next acceptance is edge E0+WIDTH+2, i.e. `start` is held or reasserted in the first IDLE cycle.
- All outputs are registered or decoded from registered state; there are no combinational paths from inputs to outputs.

## Structure
- Shared package `seq_mul_pkg` contains:
  - the state typedef `mul_state_t` {IDLE, RUN, DONE};
  - the default width constant `MUL_WIDTH` = 16.
- Single module; no sub-module is required.
- The counter, shift registers and accumulator are inline in one sequential process with a separate next-state decode.

## Test plan
- Reset held 2 cycles, then released: `busy`=0, `enable`=0, `write_word`=0x0000, `overflow`=0.
- a=3, b=5, `start` for one cycle: `enable` high for exactly one cycle, 16 edges after acceptance, with `write_word`=0x000F and `overflow`=0; `busy` high for 17 cycles.
- a=300, b=300: `write_word`=0x5F90, `overflow`=1. Then a=0xFFFF, b=0xFFFF: `write_word`=0x0001, `overflow`=1.
- a=0, b=0x1234, followed by a second `start` pulse with a=7, b=7 asserted mid-RUN: result 0x0000, `overflow`=0; the second start is ignored, giving only one `enable` pulse.
- a=9, b=9 started, `reset`=0 for one edge at RUN iteration 8: no `enable` pulse and outputs return to 0. A fresh start with a=2, b=4 then yields 0x0008 after 16 edges.
- Back-to-back: `start` held high continuously with a=10, b=10 → `enable` pulses every 18 cycles, each with `write_word`=0x0064. `write_word` is held stable between pulses.

Source files
------------

// File: rtl/seq_mul_pkg.sv
// Shared types and constants for the sequential shift-and-add multiplier.
package seq_mul_pkg;

   localparam int MUL_WIDTH = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } mul_state_t;

endpackage

// File: rtl/seq_multiplier.sv
// Unsigned shift-and-add multiplier: WIDTH iterations, then a one-cycle enable
// strobe carrying the low product half to a downstream register.
//
// state | meaning
// IDLE  | waiting for start; outputs hold the last result
// RUN   | one partial product per edge, WIDTH edges total
// DONE  | enable strobe for one cycle, then back to IDLE
module seq_multiplier
   import seq_mul_pkg::*;
#(
   parameter int WIDTH = MUL_WIDTH
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic [WIDTH-1:0] write_word,
   output logic             enable,
   output logic             overflow
);

   localparam int CNT_W = $clog2(WIDTH) + 1;

   mul_state_t         state_q, state_d;
   logic [2*WIDTH-1:0] mcand_q, mcand_d;
   logic [WIDTH-1:0]   mplier_q, mplier_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]   word_q, word_d;
   logic               ovf_q, ovf_d;
   logic [2*WIDTH-1:0] acc_sum;

   assign acc_sum = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

   always_comb begin
      state_d  = state_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      word_d   = word_q;
      ovf_d    = ovf_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               mcand_d  = {{WIDTH{1'b0}}, a};
               mplier_d = b;
               acc_d    = '0;
               cnt_d    = '0;
               state_d  = RUN;
            end
         end
         RUN: begin
            acc_d    = acc_sum;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 1'b1;
            // Last iteration: publish the freshly accumulated product.
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
               state_d = DONE;
               word_d  = acc_sum[WIDTH-1:0];
               ovf_d   = |acc_sum[2*WIDTH-1:WIDTH];
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q  <= IDLE;
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         word_q   <= '0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         word_q   <= word_d;
         ovf_q    <= ovf_d;
      end
   end

   assign busy       = (state_q != IDLE);
   assign enable     = (state_q == DONE);
   assign write_word = word_q;
   assign overflow   = ovf_q;

endmodule
